// File: rtl/sig_hs_tx.sv
`timescale 1ns/1ps
// sig_hs_tx: source half of a two-phase toggle handshake. Holds each accepted word on
// cdc_data_o, announces it by toggling cdc_req_o, and waits for the synchronized ack toggle.
module sig_hs_tx #(
  parameter int DATA_WTH = 32,
  parameter int SYNC_DLY = 2,
  parameter int TMO_CYC  = 0
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                src_vld_i,
  output logic                src_rdy_o,
  input  logic [DATA_WTH-1:0] src_data_i,
  output logic                cdc_req_o,
  output logic [DATA_WTH-1:0] cdc_data_o,
  input  logic                cdc_ack_i,
  output logic                busy_o,
  output logic                tmo_err_o,
  input  logic                tmo_clr_i
);
  localparam int TMO_W = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  state_t              state;
  state_t              state_nxt;
  logic [SYNC_DLY-1:0] ack_sync;
  logic                ack_s;
  logic                accept;
  logic                tmo_set;

  // Ack synchronizer chain; the only reader of cdc_ack_i.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ack_sync <= {SYNC_DLY{1'b0}};
    end else begin
      ack_sync <= {ack_sync[SYNC_DLY-2:0], cdc_ack_i};
    end
  end

  assign ack_s = ack_sync[SYNC_DLY-1];

  // State register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and accept strobe.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (src_vld_i) begin
          accept    = 1'b1;
          state_nxt = ST_WAIT;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (ack_s == cdc_req_o) begin
          state_nxt = ST_IDLE;
        end else begin
          state_nxt = ST_WAIT;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign src_rdy_o = (state == ST_IDLE);
  assign busy_o    = (state == ST_WAIT);

  // Request toggle and held word; both change only on the accept edge.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cdc_req_o  <= 1'b0;
      cdc_data_o <= {DATA_WTH{1'b0}};
    end else if (accept) begin
      cdc_req_o  <= ~cdc_req_o;
      cdc_data_o <= src_data_i;
    end
  end

  generate
    if (TMO_CYC > 0) begin : g_tmo
      logic [TMO_W-1:0] tmo_cnt;

      // Saturating count of WAIT cycles for the current transfer.
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          tmo_cnt <= {TMO_W{1'b0}};
        end else if (accept) begin
          tmo_cnt <= {TMO_W{1'b0}};
        end else if ((state == ST_WAIT) && (tmo_cnt != TMO_W'(TMO_CYC))) begin
          tmo_cnt <= tmo_cnt + {{(TMO_W-1){1'b0}}, 1'b1};
        end
      end

      // Fires once, on the cycle the count steps onto TMO_CYC, so a clear stays effective.
      assign tmo_set = (state == ST_WAIT) && (tmo_cnt == TMO_W'(TMO_CYC - 1));
    end else begin : g_no_tmo
      assign tmo_set = 1'b0;
    end
  endgenerate

  // Sticky timeout flag; a set in the same cycle as a clear wins.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      tmo_err_o <= 1'b0;
    end else if (tmo_set) begin
      tmo_err_o <= 1'b1;
    end else if (tmo_clr_i) begin
      tmo_err_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sig_hs_tx.sv
`timescale 1ns/1ps
// Scoreboard bench for sig_hs_tx: directed loopback/delay/timeout/reset cases plus a
// destination model on an unrelated clock.
module tb_sig_hs_tx;
  localparam int DW  = 32;
  localparam int SD  = 2;
  localparam int TMO = 10;

  logic          clk = 1'b0;
  logic          dclk = 1'b0;
  logic          rst = 1'b1;
  logic          src_vld = 1'b0;
  logic          src_rdy;
  logic [DW-1:0] src_data = '0;
  logic          cdc_req;
  logic [DW-1:0] cdc_data;
  logic          cdc_ack;
  logic          busy;
  logic          tmo_err;
  logic          tmo_clr = 1'b0;

  logic [1:0]    mode = 2'd0;   // 0 loopback, 1 manual ack, 2 destination model
  logic          ack_man = 1'b0;
  logic          dst_ack = 1'b0;
  bit            dst_en = 1'b0;

  int            checks = 0;
  int            failures = 0;
  int            cyc = 0;
  int            dst_rx = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] dst_q[$];

  always #5 clk = ~clk;
  initial begin
    #1.3;
    forever #6.85 dclk = ~dclk;
  end
  always @(posedge clk) cyc <= cyc + 1;

  assign cdc_ack = (mode == 2'd0) ? cdc_req : ((mode == 2'd1) ? ack_man : dst_ack);

  sig_hs_tx #(.DATA_WTH(DW), .SYNC_DLY(SD), .TMO_CYC(TMO)) dut (
    .clk_i(clk), .rst_i(rst),
    .src_vld_i(src_vld), .src_rdy_o(src_rdy), .src_data_i(src_data),
    .cdc_req_o(cdc_req), .cdc_data_o(cdc_data), .cdc_ack_i(cdc_ack),
    .busy_o(busy), .tmo_err_o(tmo_err), .tmo_clr_i(tmo_clr)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_rdy(output int n);
    n = 0;
    while (!src_rdy && n < 500) begin
      step(1);
      n++;
    end
    chk("rdy_return", src_rdy, 1);
  endtask

  // Present a word; push the expectation when it is accepted; return the accept cycle.
  task automatic send(input logic [DW-1:0] d, output int acc);
    int n = 0;
    acc = -1;
    src_data = d;
    src_vld  = 1'b1;
    while (!src_rdy && n < 500) begin
      step(1);
      n++;
    end
    chk("send_rdy", src_rdy, 1);
    if (src_rdy) begin
      acc = cyc;
      exp_q.push_back(d);
      if (dst_en) dst_q.push_back(d);
      step(1);
    end
  endtask

  // Source-side monitor: each request toggle pops one expected word; otherwise data must hold.
  logic          last_req = 1'b0;
  logic [DW-1:0] held = '0;
  logic [DW-1:0] e;
  always @(negedge clk) begin
    if (rst) begin
      last_req = 1'b0;
      held     = '0;
    end else if (cdc_req !== last_req) begin
      last_req = cdc_req;
      if (exp_q.size() == 0) begin
        chk("req_unexpected", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        chk("req_data", cdc_data, e);
      end
      held = cdc_data;
    end else begin
      chk("data_hold", cdc_data, held);
    end
  end

  // Destination model: synchronize req, sample data, ack after a random delay.
  logic          ds1 = 1'b0, ds2 = 1'b0, dlast = 1'b0, dpend = 1'b0;
  int            dcnt = 0;
  logic [DW-1:0] de;
  always @(posedge dclk) begin
    ds1 <= cdc_req;
    ds2 <= ds1;
    if (!dst_en) begin
      dlast   <= ds2;
      dst_ack <= cdc_req;
      dpend   <= 1'b0;
    end else if (dpend) begin
      if (dcnt == 0) begin
        dst_ack <= ~dst_ack;
        dpend   <= 1'b0;
      end else begin
        dcnt <= dcnt - 1;
      end
    end else if (ds2 != dlast) begin
      dlast <= ds2;
      dst_rx++;
      if (dst_q.size() == 0) begin
        chk("dst_unexpected", dst_q.size(), 1);
      end else begin
        de = dst_q.pop_front();
        chk("dst_data", cdc_data, de);
      end
      dcnt  <= $urandom_range(0, 6);
      dpend <= 1'b1;
    end
  end

  initial begin
    int acc[8];
    int c0;
    int n;

    // Reset values
    step(2);
    chk("rst_outputs", {src_rdy, cdc_req, cdc_data, busy, tmo_err},
        {1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
    #2 rst = 1'b0;
    step(1);
    chk("rst_rdy", src_rdy, 1);

    // Loopback stream: one word every SD+2 cycles
    mode = 2'd0;
    for (int i = 0; i < 8; i++) send(32'hA5A5_0001 + 32'(i), acc[i]);
    src_vld = 1'b0;
    wait_rdy(n);
    chk("stream_total", cyc - acc[0], 32);
    for (int i = 1; i < 8; i++) chk("stream_gap", acc[i] - acc[i-1], SD + 2);

    // Delayed ack with changing src_data during WAIT
    step(2);
    ack_man = cdc_req;
    mode    = 2'd1;
    send(32'hDEAD_BEEF, c0);
    src_data = 32'h0BAD_0BAD;
    for (int i = 0; i < 20; i++) begin
      chk("delay_busy", busy, 1);
      step(1);
    end
    src_vld = 1'b0;
    chk("delay_data", cdc_data, 32'hDEAD_BEEF);
    chk("delay_tmo", tmo_err, 1);
    ack_man = ~ack_man;
    wait_rdy(n);
    chk("ack_to_rdy", n, SD + 1);
    tmo_clr = 1'b1;
    step(1);
    tmo_clr = 1'b0;
    chk("delay_clr", tmo_err, 0);

    // Timeout: set in cycle TMO+1, set beats a simultaneous clear, then late ack completes
    step(2);
    send(32'h5555_AAAA, c0);
    src_vld = 1'b0;
    step(TMO - 1);
    chk("tmo_before", tmo_err, 0);
    tmo_clr = 1'b1;
    step(1);
    chk("tmo_rise_set_wins", tmo_err, 1);
    step(1);
    tmo_clr = 1'b0;
    chk("tmo_clr", tmo_err, 0);
    step(3);
    chk("tmo_stay_clr", tmo_err, 0);
    ack_man = ~ack_man;
    wait_rdy(n);
    chk("late_ack", n, SD + 1);
    chk("tmo_after", tmo_err, 0);

    // Asynchronous reset mid-transfer, destination reset together
    step(2);
    send(32'hCAFE_F00D, c0);
    src_vld = 1'b0;
    step(12);
    chk("rmt_tmo", tmo_err, 1);
    chk("rmt_busy", busy, 1);
    #3;
    rst     = 1'b1;
    ack_man = 1'b0;
    #1;
    chk("rmt_outputs", {src_rdy, cdc_req, cdc_data, busy, tmo_err},
        {1'b1, 1'b0, 32'h0000_0000, 1'b0, 1'b0});
    step(2);
    #2 rst = 1'b0;
    step(1);
    chk("rmt_rdy", src_rdy, 1);
    mode = 2'd0;
    send(32'h1234_5678, c0);
    src_vld = 1'b0;
    wait_rdy(n);
    chk("rmt_loop", cyc - c0, SD + 2);

    // Random CDC against the destination model
    step(4);
    dst_en = 1'b1;
    mode   = 2'd2;
    for (int i = 0; i < 1000; i++) begin
      src_vld = 1'b0;
      step($urandom_range(0, 3));
      send($urandom, c0);
    end
    src_vld = 1'b0;
    n = 0;
    while ((dst_rx < 1000 || !src_rdy) && n < 5000) begin
      step(1);
      n++;
    end
    step(2);
    chk("rand_rx", dst_rx, 1000);
    chk("rand_exp_q", exp_q.size(), 0);
    chk("rand_dst_q", dst_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
